// File: rtl/vava_pkg.sv
// Shared vector-datapath types and sizing for the register-file write-back path.
package vava_pkg;

  localparam int REG_LEN  = 64;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int ELEM_W   = 8;
  localparam int NB       = REG_LEN / ELEM_W;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [REG_LEN-1:0] data;
    logic [NB-1:0]      be;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/vreg_byte_merge.sv
// Per-lane merge of new result bytes with old register bytes.
module vreg_byte_merge #(
  parameter int NB     = 8,
  parameter int ELEM_W = 8
) (
  input  logic [NB-1:0]        be_i,
  input  logic [NB*ELEM_W-1:0] new_data_i,
  input  logic [NB*ELEM_W-1:0] old_data_i,
  output logic [NB*ELEM_W-1:0] merged_o
);

  // Each enabled lane takes the new byte, the rest keep the old contents.
  always_comb begin
    // NOTE: assign a full default first so every bit is written on every path; no latch.
    merged_o = old_data_i;
    for (int i = 0; i < NB; i++) begin
      if (be_i[i]) merged_o[i*ELEM_W +: ELEM_W] = new_data_i[i*ELEM_W +: ELEM_W];
    end
  end

endmodule

// File: rtl/vreg_writeback_arbiter.sv
// Write-back stage: round-robin ALU/LSU arbitration, one stage register,
// read-merge-write into the full-register write port, commit pulse per retire.
module vreg_writeback_arbiter
  import vava_pkg::*;
(
  input  logic               clk,
  input  logic               nreset,
  input  logic               alu_valid_i,
  output logic               alu_ready_o,
  input  logic [ADDR_W-1:0]  alu_addr_i,
  input  logic [REG_LEN-1:0] alu_data_i,
  input  logic [NB-1:0]      alu_be_i,
  input  logic               lsu_valid_i,
  output logic               lsu_ready_o,
  input  logic [ADDR_W-1:0]  lsu_addr_i,
  input  logic [REG_LEN-1:0] lsu_data_i,
  input  logic [NB-1:0]      lsu_be_i,
  input  logic               wb_stall_i,
  output logic [ADDR_W-1:0]  rf_rd_addr_o,
  output logic [NB-1:0]      rf_rd_en_o,
  input  logic [REG_LEN-1:0] rf_rd_data_i,
  output logic               rf_wr_en_o,
  output logic [ADDR_W-1:0]  rf_wr_addr_o,
  output logic [REG_LEN-1:0] rf_wr_data_o,
  output logic               commit_valid_o,
  output logic [ADDR_W-1:0]  commit_addr_o,
  output logic               commit_src_o
);

  logic    stage_valid_q, stage_valid_d;
  wb_src_e stage_src_q, stage_src_d;
  wb_req_t stage_req_q, stage_req_d;
  wb_src_e rr_ptr_q, rr_ptr_d;

  logic    stage_free;
  logic    accept;
  logic    retire;
  wb_src_e grant_src;
  logic [REG_LEN-1:0] merged_data;

  assign stage_free = !stage_valid_q || !wb_stall_i;
  assign retire     = stage_valid_q && !wb_stall_i;

  // Grant selection and next-state of the stage register and round-robin pointer.
  always_comb begin
    grant_src = WB_ALU;
    if (alu_valid_i && lsu_valid_i) grant_src = rr_ptr_q;
    else if (lsu_valid_i)           grant_src = WB_LSU;

    accept      = stage_free && (alu_valid_i || lsu_valid_i);
    alu_ready_o = stage_free && alu_valid_i && (grant_src == WB_ALU);
    lsu_ready_o = stage_free && lsu_valid_i && (grant_src == WB_LSU);

    stage_valid_d = stage_valid_q;
    stage_src_d   = stage_src_q;
    stage_req_d   = stage_req_q;
    rr_ptr_d      = rr_ptr_q;
    if (accept) begin
      stage_valid_d = 1'b1;
      stage_src_d   = grant_src;
      stage_req_d   = (grant_src == WB_LSU) ? '{addr: lsu_addr_i, data: lsu_data_i, be: lsu_be_i}
                                            : '{addr: alu_addr_i, data: alu_data_i, be: alu_be_i};
      rr_ptr_d      = wb_src_e'(~grant_src);
    end else if (stage_free) begin
      stage_valid_d = 1'b0;
    end
  end

  // Stage register and arbitration pointer; reset drops any in-flight request.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stage_valid_q <= 1'b0;
      stage_src_q   <= WB_ALU;
      stage_req_q   <= '0;
      rr_ptr_q      <= WB_ALU;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      stage_valid_q <= stage_valid_d;
      stage_src_q   <= stage_src_d;
      stage_req_q   <= stage_req_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  vreg_byte_merge #(
    .NB     (NB),
    .ELEM_W (ELEM_W)
  ) u_merge (
    .be_i       (stage_req_q.be),
    .new_data_i (stage_req_q.data),
    .old_data_i (rf_rd_data_i),
    .merged_o   (merged_data)
  );

  // Retire-cycle outputs; everything is held at zero while idle or stalled.
  always_comb begin
    rf_rd_addr_o   = '0;
    rf_rd_en_o     = '0;
    rf_wr_en_o     = 1'b0;
    rf_wr_addr_o   = '0;
    rf_wr_data_o   = '0;
    commit_valid_o = 1'b0;
    commit_addr_o  = '0;
    commit_src_o   = 1'b0;
    if (retire) begin
      rf_rd_addr_o   = stage_req_q.addr;
      rf_rd_en_o     = ~stage_req_q.be;
      rf_wr_en_o     = (stage_req_q.addr != '0) && (stage_req_q.be != '0);
      rf_wr_addr_o   = stage_req_q.addr;
      rf_wr_data_o   = merged_data;
      commit_valid_o = 1'b1;
      commit_addr_o  = stage_req_q.addr;
      commit_src_o   = stage_src_q;
    end
  end

endmodule

// File: tb/tb_vreg_writeback_arbiter.sv
// Directed bench for the write-back arbiter with a small register-file model.
module tb_vreg_writeback_arbiter;
  import vava_pkg::*;

  logic               clk = 1'b0;
  logic               nreset;
  logic               alu_valid, alu_ready, lsu_valid, lsu_ready, wb_stall;
  logic [ADDR_W-1:0]  alu_addr, lsu_addr, rf_rd_addr, rf_wr_addr, commit_addr;
  logic [REG_LEN-1:0] alu_data, lsu_data, rf_rd_data, rf_wr_data;
  logic [NB-1:0]      alu_be, lsu_be, rf_rd_en;
  logic               rf_wr_en, commit_valid, commit_src;

  logic [REG_LEN-1:0] rf_mem [NUM_REGS];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rf_rd_data = rf_mem[rf_rd_addr];

  always @(posedge clk) begin
    if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
  end

  vreg_writeback_arbiter dut (
    .clk            (clk),
    .nreset         (nreset),
    .alu_valid_i    (alu_valid),
    .alu_ready_o    (alu_ready),
    .alu_addr_i     (alu_addr),
    .alu_data_i     (alu_data),
    .alu_be_i       (alu_be),
    .lsu_valid_i    (lsu_valid),
    .lsu_ready_o    (lsu_ready),
    .lsu_addr_i     (lsu_addr),
    .lsu_data_i     (lsu_data),
    .lsu_be_i       (lsu_be),
    .wb_stall_i     (wb_stall),
    .rf_rd_addr_o   (rf_rd_addr),
    .rf_rd_en_o     (rf_rd_en),
    .rf_rd_data_i   (rf_rd_data),
    .rf_wr_en_o     (rf_wr_en),
    .rf_wr_addr_o   (rf_wr_addr),
    .rf_wr_data_o   (rf_wr_data),
    .commit_valid_o (commit_valid),
    .commit_addr_o  (commit_addr),
    .commit_src_o   (commit_src)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    nreset = 1'b0; wb_stall = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0; alu_be = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0; lsu_be = '0;
    #2;
    check("rst_wr_en",    rf_wr_en, 0);
    check("rst_commit",   commit_valid, 0);
    check("rst_rd_en",    rf_rd_en, 0);
    check("rst_rd_addr",  rf_rd_addr, 0);
    check("rst_wr_data",  rf_wr_data, 0);
    check("rst_readies",  {alu_ready, lsu_ready}, 0);
    @(negedge clk); nreset = 1'b1;

    // Full-register ALU write to v3.
    alu_valid = 1'b1; alu_addr = 3; alu_data = 64'h1122334455667788; alu_be = 8'hFF;
    #1 check("t1_alu_ready", alu_ready, 1);
    @(negedge clk); alu_valid = 1'b0;
    #1;
    check("t1_wr_en",    rf_wr_en, 1);
    check("t1_wr_addr",  rf_wr_addr, 3);
    check("t1_wr_data",  rf_wr_data, 64'h1122334455667788);
    check("t1_rd_en",    rf_rd_en, 0);
    check("t1_commit",   {commit_valid, commit_addr, commit_src}, {1'b1, 3'd3, 1'b0});

    // Preload v2 with 0xAA.., then a partial LSU write into it.
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 2; alu_data = {8{8'hAA}}; alu_be = 8'hFF;
    @(negedge clk);
    alu_valid = 1'b0;
    lsu_valid = 1'b1; lsu_addr = 2; lsu_data = {8{8'h55}}; lsu_be = 8'h0F;
    @(negedge clk);
    lsu_valid = 1'b0;
    #1;
    check("t2_wr_data",  rf_wr_data, 64'hAAAAAAAA55555555);
    check("t2_rd_en",    rf_rd_en, 8'hF0);
    check("t2_rd_addr",  rf_rd_addr, 2);
    check("t2_src",      commit_src, 1);

    // Fresh reset, then both sources valid for four cycles.
    @(negedge clk); nreset = 1'b0; #1 nreset = 1'b1;
    alu_valid = 1'b1; alu_addr = 1; alu_data = {8{8'h11}}; alu_be = 8'hFF;
    lsu_valid = 1'b1; lsu_addr = 4; lsu_data = {8{8'h44}}; lsu_be = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_alu_ready_%0d", i), alu_ready, (i % 2 == 0));
      check($sformatf("t3_lsu_ready_%0d", i), lsu_ready, (i % 2 == 1));
      @(negedge clk);
      #1;
      check($sformatf("t3_commit_src_%0d", i), {commit_valid, commit_src}, {1'b1, (i % 2 == 1)});
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // Writes to v0 and with all-zero byte enables are dropped but still commit.
    alu_valid = 1'b1; alu_addr = 0; alu_data = {8{8'hEE}}; alu_be = 8'hFF;
    @(negedge clk);
    alu_addr = 6; alu_be = 8'h00;
    #1;
    check("t4_v0_wr_en",   rf_wr_en, 0);
    check("t4_v0_commit",  {commit_valid, commit_addr}, {1'b1, 3'd0});
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    check("t4_be0_wr_en",  rf_wr_en, 0);
    check("t4_be0_commit", {commit_valid, commit_addr}, {1'b1, 3'd6});

    // Stall with a request held in the stage and another one waiting.
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 6; alu_data = {8{8'h66}}; alu_be = 8'hFF;
    @(negedge clk);
    alu_valid = 1'b0; wb_stall = 1'b1;
    lsu_valid = 1'b1; lsu_addr = 7; lsu_data = {8{8'h77}}; lsu_be = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t5_stall_wr_%0d", i),  {rf_wr_en, commit_valid}, 0);
      check($sformatf("t5_stall_rd_%0d", i),  rf_rd_en, 0);
      check($sformatf("t5_stall_rdy_%0d", i), {alu_ready, lsu_ready}, 0);
      @(negedge clk);
    end
    wb_stall = 1'b0;
    #1;
    check("t5_release_wr",   {rf_wr_en, rf_wr_addr}, {1'b1, 3'd6});
    check("t5_release_data", rf_wr_data, {8{8'h66}});
    check("t5_release_rdy",  lsu_ready, 1);
    @(negedge clk);
    lsu_valid = 1'b0;
    #1;
    check("t5_next_wr", {rf_wr_en, rf_wr_addr, commit_src}, {1'b1, 3'd7, 1'b1});

    // Back-to-back partial writes to v5 over an all-ones old value.
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5; alu_data = '1; alu_be = 8'hFF;
    @(negedge clk);
    alu_data = 64'h01; alu_be = 8'h01;
    @(negedge clk);
    alu_data = 64'h0200; alu_be = 8'h02;
    #1;
    check("t6_first_data",  rf_wr_data, 64'hFFFFFFFFFFFFFF01);
    check("t6_first_rd_en", rf_rd_en, 8'hFE);
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    check("t6_second_data",  rf_wr_data, 64'hFFFFFFFFFFFF0201);
    check("t6_second_rd_en", rf_rd_en, 8'hFD);
    check("t6_second_wr_en", rf_wr_en, 1);

    // Reset while a request sits in the stage.
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 4; alu_data = {8{8'h99}}; alu_be = 8'hFF;
    @(negedge clk);
    alu_valid = 1'b0; nreset = 1'b0;
    #1;
    check("t7_rst_wr",     {rf_wr_en, commit_valid}, 0);
    check("t7_rst_data",   rf_wr_data, 0);
    check("t7_rst_addr",   {rf_rd_addr, rf_wr_addr, commit_addr}, 0);
    @(negedge clk);
    check("t7_v4_kept",    rf_mem[4], {8{8'h44}});
    nreset = 1'b1;
    #1;
    check("t7_idle_after", commit_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
